// File: rtl/uart_stim_tx_pkg.sv
// Shared definitions for the bench-side UART stimulus transmitter and its decoder.
// Holds the line FSM encoding and the clock-to-baud divisor rule used at both ends.
// No logic of its own; both ends call baud_div so they agree on the bit period.
package uart_stim_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Rounded integer divisor: cycles of the reference clock per bit.
    function automatic int unsigned baud_div(input int unsigned clk_freq_hz,
                                             input int unsigned baud);
        return (clk_freq_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_stim_fifo.sv
// Byte queue in front of the UART serialiser; registered pointers with a wrap bit.
// Latency: a write is visible at the head (empty low) one edge after it is accepted.
// Backpressure: writes while full and reads while empty are ignored.
module uart_stim_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_stim_tx.sv
// Queued 8N1 UART transmitter driving the SoC receive pin from bench stimulus.
// Latency: byte accepted on edge N starts its start bit after edge N+1; frame = 10*DIV cycles.
// Backpressure: o_ready is low while the byte queue is full; i_data is ignored then.
module uart_stim_tx
    import uart_stim_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 25_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int unsigned DIV = baud_div(CLK_FREQ_HZ, BAUD);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_bad_div
        $error("uart_stim_tx: baud divisor must be at least 2");
    end

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_stim_tx: FIFO_DEPTH must be a power of two and at least 2");
    end

    tx_state_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              pop;
    logic              baud_end;

    logic [7:0]                    fifo_head;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;

    uart_stim_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (i_valid),
        .wr_data (i_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign baud_end = (cnt_q == CW'(DIV - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        pop      = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end

            START: begin
                if (baud_end) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end
            end

            // tx is a flop, so the next bit is presented from the post-shift value.
            DATA: begin
                if (baud_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end

            STOP: begin
                if (baud_end) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                cnt_d   = '0;
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign o_tx    = tx_q;
    assign o_ready = !fifo_full;
    assign o_level = fifo_count;
    assign o_busy  = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_stim_tx.sv
// Two transmitters (default divisor 217 and 50M/1M divisor 50) checked every cycle against
// a frame-schedule model, plus directed vectors for frame timing, full queue and reset.
module tb_uart_stim_tx;

    localparam int DIV0  = 217;
    localparam int DIV1  = 50;
    localparam int DEPTH = 16;
    localparam int MAXF  = 256;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0][7:0] dat;
    logic [1:0]      vld;
    logic [1:0]      rdy;
    logic [1:0]      tx;
    logic [1:0]      busy;
    logic [1:0][4:0] lvl;

    int   acc_t [2][MAXF];
    int   st_t  [2][MAXF];
    logic [7:0] fb [2][MAXF];
    int   nf [2];
    int   cyc;
    int   total;
    int   bad;
    logic [1:0] took;

    typedef struct {
        int         d;
        bit         newgrp;
        bit         wr;
        logic [7:0] data;
        int         at;
        logic       etx;
        logic       ebusy;
        int         elvl;
    } vec_t;

    vec_t vt[$];

    uart_stim_tx u_dut0 (
        .clk     (clk),
        .rst     (rst),
        .i_data  (dat[0]),
        .i_valid (vld[0]),
        .o_ready (rdy[0]),
        .o_tx    (tx[0]),
        .o_busy  (busy[0]),
        .o_level (lvl[0])
    );

    uart_stim_tx #(
        .CLK_FREQ_HZ (50_000_000),
        .BAUD        (1_000_000)
    ) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .i_data  (dat[1]),
        .i_valid (vld[1]),
        .o_ready (rdy[1]),
        .o_tx    (tx[1]),
        .o_busy  (busy[1]),
        .o_level (lvl[1])
    );

    initial forever #20 clk = ~clk;

    function automatic int divof(input int d);
        return (d == 0) ? DIV0 : DIV1;
    endfunction

    // Bytes accepted up to edge e minus frames whose start bit began by edge e.
    function automatic int m_level(input int d, input int e);
        int c = 0;
        for (int k = 0; k < nf[d]; k++) begin
            if (acc_t[d][k] <= e) c++;
            if (st_t[d][k] <= e)  c--;
        end
        return c;
    endfunction

    function automatic int m_active(input int d, input int e);
        int r = -1;
        for (int k = 0; k < nf[d]; k++)
            if (st_t[d][k] <= e && e < st_t[d][k] + 10 * divof(d)) r = k;
        return r;
    endfunction

    function automatic logic m_tx(input int d, input int e);
        int k = m_active(d, e);
        int b;
        if (k < 0) return 1'b1;
        b = (e - st_t[d][k]) / divof(d);
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return fb[d][k][b-1];
    endfunction

    function automatic logic m_busy(input int d, input int e);
        return (m_level(d, e) > 0) || (m_active(d, e) >= 0);
    endfunction

    task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, d, cyc, act, exp);
        end
    endtask

    task automatic check_cycle();
        for (int d = 0; d < 2; d++) begin
            chk(d, "tx",    32'(tx[d]),   32'(m_tx(d, cyc)));
            chk(d, "level", 32'(lvl[d]),  32'(m_level(d, cyc)));
            chk(d, "ready", 32'(rdy[d]),  32'(m_level(d, cyc) < DEPTH));
            chk(d, "busy",  32'(busy[d]), 32'(m_busy(d, cyc)));
        end
    endtask

    // One clock: book accepted writes into the schedule, advance, compare at the falling edge.
    task automatic tick();
        int e;
        int st;
        for (int d = 0; d < 2; d++) begin
            took[d] = 1'b0;
            if (vld[d] && m_level(d, cyc) < DEPTH) begin
                e  = cyc + 1;
                st = e + 1;
                if (nf[d] > 0 && st_t[d][nf[d]-1] + 10 * divof(d) > st)
                    st = st_t[d][nf[d]-1] + 10 * divof(d);
                acc_t[d][nf[d]] = e;
                st_t[d][nf[d]]  = st;
                fb[d][nf[d]]    = dat[d];
                nf[d]++;
                took[d] = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic add_v(input int d, input bit ng, input bit wr, input logic [7:0] data,
                         input int at, input logic etx, input logic ebusy, input int elvl);
        vec_t v;
        v.d = d; v.newgrp = ng; v.wr = wr; v.data = data;
        v.at = at; v.etx = etx; v.ebusy = ebusy; v.elvl = elvl;
        vt.push_back(v);
    endtask

    initial begin
        int base;
        int got_at;
        rst = 1'b1; vld = '0; dat = '0;
        cyc = 0; total = 0; bad = 0; nf[0] = 0; nf[1] = 0; took = '0;

        // Single 0x55 at divisor 217
        add_v(0, 1, 1, 8'h55,    0, 1, 1, 1);
        add_v(0, 0, 0, 8'h00,    1, 0, 1, 0);
        add_v(0, 0, 0, 8'h00,  217, 0, 1, 0);
        add_v(0, 0, 0, 8'h00,  218, 1, 1, 0);
        add_v(0, 0, 0, 8'h00,  435, 0, 1, 0);
        add_v(0, 0, 0, 8'h00,  652, 1, 1, 0);
        add_v(0, 0, 0, 8'h00, 1736, 1, 1, 0);
        add_v(0, 0, 0, 8'h00, 1737, 0, 1, 0);
        add_v(0, 0, 0, 8'h00, 1954, 1, 1, 0);
        add_v(0, 0, 0, 8'h00, 2170, 1, 1, 0);
        add_v(0, 0, 0, 8'h00, 2171, 1, 0, 0);
        // Three back-to-back bytes
        add_v(0, 1, 1, 8'h00,    0, 1, 1, 1);
        add_v(0, 0, 1, 8'hFF,    1, 0, 1, 1);
        add_v(0, 0, 1, 8'hA5,    2, 0, 1, 2);
        add_v(0, 0, 0, 8'h00,  218, 0, 1, 2);
        add_v(0, 0, 0, 8'h00, 2170, 1, 1, 2);
        add_v(0, 0, 0, 8'h00, 2171, 0, 1, 1);
        add_v(0, 0, 0, 8'h00, 2388, 1, 1, 1);
        add_v(0, 0, 0, 8'h00, 4341, 0, 1, 0);
        add_v(0, 0, 0, 8'h00, 4558, 1, 1, 0);
        add_v(0, 0, 0, 8'h00, 4775, 0, 1, 0);
        add_v(0, 0, 0, 8'h00, 6510, 1, 1, 0);
        add_v(0, 0, 0, 8'h00, 6511, 1, 0, 0);
        // 0x80 at divisor 50
        add_v(1, 1, 1, 8'h80,    0, 1, 1, 1);
        add_v(1, 0, 0, 8'h00,    1, 0, 1, 0);
        add_v(1, 0, 0, 8'h00,  400, 0, 1, 0);
        add_v(1, 0, 0, 8'h00,  401, 1, 1, 0);
        add_v(1, 0, 0, 8'h00,  450, 1, 1, 0);
        add_v(1, 0, 0, 8'h00,  451, 1, 1, 0);
        add_v(1, 0, 0, 8'h00,  500, 1, 1, 0);
        add_v(1, 0, 0, 8'h00,  501, 1, 0, 0);

        #10;
        for (int d = 0; d < 2; d++) begin
            chk(d, "rst_tx",    32'(tx[d]),   32'd1);
            chk(d, "rst_ready", 32'(rdy[d]),  32'd1);
            chk(d, "rst_busy",  32'(busy[d]), 32'd0);
            chk(d, "rst_level", 32'(lvl[d]),  32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        base = 0;
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].newgrp) base = cyc + 1;
            while (cyc - base < vt[i].at - 1) tick();
            if (vt[i].wr) begin
                vld[vt[i].d] = 1'b1;
                dat[vt[i].d] = vt[i].data;
            end
            tick();
            vld = '0;
            chk(vt[i].d, "vec_tx",    32'(tx[vt[i].d]),   32'(vt[i].etx));
            chk(vt[i].d, "vec_busy",  32'(busy[vt[i].d]), 32'(vt[i].ebusy));
            chk(vt[i].d, "vec_level", 32'(lvl[vt[i].d]),  32'(vt[i].elvl));
        end

        // Full queue on divisor 50: 17 writes, then an 18th held until after the second pop
        base = cyc + 1;
        vld[1] = 1'b1;
        for (int i = 0; i < 17; i++) begin
            dat[1] = 8'h41 + 8'(i);
            tick();
        end
        chk(1, "full_ready", 32'(rdy[1]), 32'd0);
        chk(1, "full_level", 32'(lvl[1]), 32'd16);
        dat[1] = 8'h52;
        got_at = -1;
        for (int i = 0; i < 1000 && got_at < 0; i++) begin
            tick();
            if (cyc - base == 501) begin
                chk(1, "pop_ready", 32'(rdy[1]), 32'd1);
                chk(1, "pop_level", 32'(lvl[1]), 32'd15);
            end
            if (took[1]) got_at = cyc - base;
        end
        vld = '0;
        chk(1, "held_accept_edge", 32'(got_at), 32'd502);
        for (int i = 0; i < 10000 && (busy[1] || m_busy(1, cyc)); i++) tick();
        chk(1, "drained", 32'(busy[1]), 32'd0);

        // Asynchronous reset 1000 cycles into a frame with three bytes queued
        base = cyc + 1;
        vld[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dat[0] = 8'h11 * 8'(i + 1);
            tick();
        end
        vld = '0;
        while (cyc - base < 1001) tick();
        chk(0, "pre_rst_level", 32'(lvl[0]), 32'd3);
        #5 rst = 1'b1;
        #1;
        chk(0, "async_tx",    32'(tx[0]),   32'd1);
        chk(0, "async_level", 32'(lvl[0]),  32'd0);
        chk(0, "async_busy",  32'(busy[0]), 32'd0);
        nf[0] = 0;
        nf[1] = 0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2500; i++) tick();

        // Random bursts: heavy phases overrun the queue, quiet phases let it drain
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < ((ph % 2 == 0) ? 700 : 1200); i++) begin
                vld = '0;
                if (ph % 2 == 0) begin
                    vld[1] = ($urandom_range(0, 19) == 0) && (nf[1] < MAXF - 2);
                    vld[0] = ($urandom_range(0, 299) == 0) && (nf[0] < MAXF - 2);
                end
                dat[0] = 8'($urandom);
                dat[1] = 8'($urandom);
                tick();
            end
        end
        vld = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
